// File: rtl/systolic_array_host.sv
// systolic_array_host
//
// Host-side sequencer for the systolic array driver. It collects one job's
// operand words from a loader, streams them to the driver over valid/ready,
// waits for the driver to finish computing, pulses flush, then captures the
// result words that come back over valid/yumi into a readable result buffer.
//
// Ports
//   clk_i, reset_ni            clock, synchronous active-low reset
//   start_i                    begin job (IDLE_S) / acknowledge results (DONE_S)
//   ld_valid_i, ld_data_i      operand load strobe and word
//   ld_ready_o                 operand buffer accepting words
//   valid_o, data_o, ready_i   operand stream to the driver
//   flush_o                    one-cycle flush request to the driver
//   res_valid_i, res_data_i    result stream from the driver
//   yumi_o                     result word consumed this cycle
//   rd_addr_i, rd_data_o       combinational read port of the result buffer
//   done_o, busy_o             job status
//
// Optional feature (macro SYSTOLIC_HOST_PERF_EN)
//   perf_cycles_o              busy-cycle count of the most recent job
module systolic_array_host #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int steps_p        = 2
) (
  input  logic                                            clk_i,
  input  logic                                            reset_ni,
  input  logic                                            start_i,
  input  logic                                            ld_valid_i,
  input  logic [width_p-1:0]                              ld_data_i,
  output logic                                            ld_ready_o,
  output logic                                            valid_o,
  output logic [width_p-1:0]                              data_o,
  input  logic                                            ready_i,
  output logic                                            flush_o,
  input  logic                                            res_valid_i,
  input  logic [width_p-1:0]                              res_data_i,
  output logic                                            yumi_o,
  input  logic [$clog2(array_width_p*array_height_p)-1:0] rd_addr_i,
  output logic [width_p-1:0]                              rd_data_o,
  output logic                                            done_o,
`ifdef SYSTOLIC_HOST_PERF_EN
  output logic [31:0]                                     perf_cycles_o,
`endif
  output logic                                            busy_o
);

  localparam int ops_lp       = steps_p * (array_width_p + array_height_p);
  localparam int res_lp       = array_width_p * array_height_p;
  localparam int ld_cnt_w_lp  = $clog2(ops_lp + 1);
  localparam int res_cnt_w_lp = $clog2(res_lp + 1);
  localparam int op_idx_w_lp  = $clog2(ops_lp);
  localparam int res_idx_w_lp = $clog2(res_lp);

  localparam logic [ld_cnt_w_lp-1:0]  ops_full_lp = ld_cnt_w_lp'(ops_lp);
  localparam logic [ld_cnt_w_lp-1:0]  ops_last_lp = ld_cnt_w_lp'(ops_lp - 1);
  localparam logic [res_cnt_w_lp-1:0] res_full_lp = res_cnt_w_lp'(res_lp);
  localparam logic [res_cnt_w_lp-1:0] res_last_lp = res_cnt_w_lp'(res_lp - 1);

  typedef enum logic [6:0] {
    IDLE_S    = 7'b0000001,
    SEND_S    = 7'b0000010,
    WAIT_LO_S = 7'b0000100,
    WAIT_HI_S = 7'b0001000,
    FLUSH_S   = 7'b0010000,
    COLLECT_S = 7'b0100000,
    DONE_S    = 7'b1000000
  } state_e;

  state_e state_q, state_d;

  logic [ld_cnt_w_lp-1:0]  ld_cnt_q;
  logic [ld_cnt_w_lp-1:0]  send_cnt_q;
  logic [res_cnt_w_lp-1:0] res_cnt_q;

  logic [width_p-1:0] op_buf_q  [ops_lp];
  logic [width_p-1:0] res_buf_q [res_lp];

  logic op_wr;
  logic res_wr;

  // A word is accepted only while idle and the buffer has room; a result is
  // captured in the same cycle it is presented because the driver cannot stall.
  assign op_wr  = (state_q == IDLE_S) && ld_valid_i && (ld_cnt_q != ops_full_lp);
  assign res_wr = (state_q == COLLECT_S) && res_valid_i && (res_cnt_q != res_full_lp);

  // State register and the three counters. All counters saturate at their
  // terminal count so a stray strobe can never wrap them back into range.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE_S;
      ld_cnt_q   <= '0;
      send_cnt_q <= '0;
      res_cnt_q  <= '0;
    end else begin
      state_q <= state_d;

      if (op_wr) begin
        ld_cnt_q <= ld_cnt_q + 1'b1;
      end else if ((state_q == DONE_S) && start_i) begin
        ld_cnt_q <= '0;
      end

      if (state_q == IDLE_S) begin
        send_cnt_q <= '0;
      end else if ((state_q == SEND_S) && ready_i && (send_cnt_q != ops_full_lp)) begin
        send_cnt_q <= send_cnt_q + 1'b1;
      end

      if (state_q == FLUSH_S) begin
        res_cnt_q <= '0;
      end else if (res_wr) begin
        res_cnt_q <= res_cnt_q + 1'b1;
      end
    end
  end

  // Data storage carries no reset; its contents are only meaningful once the
  // corresponding counter says they were written.
  always_ff @(posedge clk_i) begin
    if (op_wr) begin
      op_buf_q[ld_cnt_q[op_idx_w_lp-1:0]] <= ld_data_i;
    end
    if (res_wr) begin
      res_buf_q[res_cnt_q[res_idx_w_lp-1:0]] <= res_data_i;
    end
  end

  // Next-state and output decode. The WAIT_LO/WAIT_HI pair detects the
  // driver's busy period: ready drops while it computes and rises when idle.
  always_comb begin
    state_d    = state_q;
    ld_ready_o = 1'b0;
    valid_o    = 1'b0;
    flush_o    = 1'b0;
    yumi_o     = 1'b0;
    done_o     = 1'b0;
    busy_o     = 1'b0;

    unique case (state_q)
      IDLE_S: begin
        ld_ready_o = (ld_cnt_q != ops_full_lp);
        if (start_i && (ld_cnt_q == ops_full_lp)) begin
          state_d = SEND_S;
        end
      end
      SEND_S: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        if (ready_i && (send_cnt_q == ops_last_lp)) begin
          state_d = WAIT_LO_S;
        end
      end
      WAIT_LO_S: begin
        busy_o = 1'b1;
        if (!ready_i) begin
          state_d = WAIT_HI_S;
        end
      end
      WAIT_HI_S: begin
        busy_o = 1'b1;
        if (ready_i) begin
          state_d = FLUSH_S;
        end
      end
      FLUSH_S: begin
        busy_o  = 1'b1;
        flush_o = 1'b1;
        state_d = COLLECT_S;
      end
      COLLECT_S: begin
        busy_o = 1'b1;
        yumi_o = res_valid_i;
        if (res_valid_i && (res_cnt_q == res_last_lp)) begin
          state_d = DONE_S;
        end
      end
      DONE_S: begin
        done_o = 1'b1;
        if (start_i) begin
          state_d = IDLE_S;
        end
      end
      default: begin
        state_d = IDLE_S;
      end
    endcase
  end

  assign data_o    = op_buf_q[send_cnt_q[op_idx_w_lp-1:0]];
  assign rd_data_o = res_buf_q[rd_addr_i];

`ifdef SYSTOLIC_HOST_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: restarts when a job launches and freezes once the
  // job leaves the busy states, so the value stays readable in DONE_S.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      perf_q <= '0;
    end else if ((state_q == IDLE_S) && (state_d == SEND_S)) begin
      perf_q <= '0;
    end else if (busy_o) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_systolic_array_host.sv
// tb_systolic_array_host
//
// Directed-plus-random bench for systolic_array_host. Expected operand and
// result streams are held as plain arrays; each cycle's outputs are compared
// against what the job's protocol says must be visible at that point.
module tb_systolic_array_host;

  logic        clk_i       = 1'b0;
  logic        reset_ni    = 1'b0;
  logic        start_i     = 1'b0;
  logic        ld_valid_i  = 1'b0;
  logic [31:0] ld_data_i   = 32'h0;
  logic        ready_i     = 1'b0;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_data_i  = 32'h0;
  logic [1:0]  rd_addr_i   = 2'd0;

  logic        ld_ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        flush_o;
  logic        yumi_o;
  logic [31:0] rd_data_o;
  logic        done_o;
  logic        busy_o;
`ifdef SYSTOLIC_HOST_PERF_EN
  logic [31:0] perf_cycles_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] ops_exp [8];
  logic [31:0] res_exp [4];

  int   sent, got, cyc, stall, hi, lo;
  logic rdy, v;

  systolic_array_host dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .ld_valid_i  (ld_valid_i),
    .ld_data_i   (ld_data_i),
    .ld_ready_o  (ld_ready_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .flush_o     (flush_o),
    .res_valid_i (res_valid_i),
    .res_data_i  (res_data_i),
    .yumi_o      (yumi_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .done_o      (done_o),
`ifdef SYSTOLIC_HOST_PERF_EN
    .perf_cycles_o (perf_cycles_o),
`endif
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle's inputs on the falling edge, then let combinational
  // outputs settle before the caller samples them.
  task automatic applyStimulus(input logic rst_n, input logic st, input logic ldv,
                               input logic [31:0] ldd, input logic rdy_in,
                               input logic rv, input logic [31:0] rdat,
                               input logic [1:0] ra);
    @(negedge clk_i);
    reset_ni    = rst_n;
    start_i     = st;
    ld_valid_i  = ldv;
    ld_data_i   = ldd;
    ready_i     = rdy_in;
    res_valid_i = rv;
    res_data_i  = rdat;
    rd_addr_i   = ra;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with a stray result strobe that must be ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 2'd0);
    checkOutput("rst_valid",    32'(valid_o),    32'd0);
    checkOutput("rst_flush",    32'(flush_o),    32'd0);
    checkOutput("rst_yumi",     32'(yumi_o),     32'd0);
    checkOutput("rst_done",     32'(done_o),     32'd0);
    checkOutput("rst_busy",     32'(busy_o),     32'd0);
    checkOutput("rst_ld_ready", 32'(ld_ready_o), 32'd1);

    // Partial load followed by an early start, which must be ignored.
    for (int i = 0; i < 5; i++) begin
      ops_exp[i] = 32'(i + 1);
      applyStimulus(1'b1, 1'b0, 1'b1, ops_exp[i], 1'b1, 1'b1, 32'hDEAD, 2'd0);
      checkOutput("ld_ready_partial", 32'(ld_ready_o), 32'd1);
      checkOutput("idle_yumi", 32'(yumi_o), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
    checkOutput("partial_start_ld_ready", 32'(ld_ready_o), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
    checkOutput("partial_start_valid", 32'(valid_o), 32'd0);
    checkOutput("partial_start_busy",  32'(busy_o),  32'd0);

    for (int i = 5; i < 8; i++) begin
      ops_exp[i] = 32'(i + 1);
      applyStimulus(1'b1, 1'b0, 1'b1, ops_exp[i], 1'b1, 1'b0, 32'h0, 2'd0);
      checkOutput("ld_ready_fill", 32'(ld_ready_o), 32'd1);
    end
    // Overflow attempt: refused, and the later send sequence proves the buffer kept 1..8.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h0, 2'd0);
    checkOutput("full_ld_ready", 32'(ld_ready_o), 32'd0);

    // Job 0: free-running ready. Job 1: three-cycle stall on the fourth word.
    // Job 2: random ready and random result gaps.
    for (int job = 0; job < 3; job++) begin
      if (job > 0) begin
        for (int i = 0; i < 8; i++) begin
          ops_exp[i] = $urandom;
          applyStimulus(1'b1, 1'b0, 1'b1, ops_exp[i], 1'b1, 1'b0, 32'h0, 2'd0);
          checkOutput("ld_ready_job", 32'(ld_ready_o), 32'd1);
        end
      end

      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
      checkOutput("start_valid", 32'(valid_o), 32'd0);

      sent  = 0;
      stall = 0;
      cyc   = 0;
      while (sent < 8 && cyc < 64) begin
        rdy = 1'b1;
        if (job == 1 && sent == 3 && stall < 3) begin
          rdy = 1'b0;
          stall++;
        end else if (job == 2) begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, rdy, 1'b0, 32'h0, 2'd0);
        checkOutput("send_valid", 32'(valid_o), 32'd1);
        checkOutput("send_data",  data_o, ops_exp[sent]);
        if (rdy) sent++;
        cyc++;
      end
      if (job == 1) checkOutput("stall_span", 32'(cyc), 32'd11);

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
      checkOutput("post_send_valid", 32'(valid_o), 32'd0);
      checkOutput("post_send_busy",  32'(busy_o),  32'd1);
      checkOutput("post_send_flush", 32'(flush_o), 32'd0);

      hi = $urandom_range(0, 2);
      for (int i = 0; i < hi; i++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
        checkOutput("wait_hi_flush", 32'(flush_o), 32'd0);
      end
      lo = (job == 0) ? 5 : int'($urandom_range(1, 6));
      for (int i = 0; i < lo; i++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd0);
        checkOutput("wait_lo_flush", 32'(flush_o), 32'd0);
        checkOutput("wait_lo_busy",  32'(busy_o),  32'd1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
      checkOutput("ready_rise_flush", 32'(flush_o), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF0000, 2'd0);
      checkOutput("flush_pulse", 32'(flush_o), 32'd1);
      checkOutput("flush_yumi",  32'(yumi_o),  32'd0);

      for (int k = 0; k < 4; k++) begin
        res_exp[k] = (job == 0) ? 32'((k + 1) * 10) : $urandom;
      end
      got = 0;
      cyc = 0;
      while (got < 4 && cyc < 64) begin
        v = (job == 2 && cyc < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, v,
                      v ? res_exp[got] : (32'hFFFF0000 | 32'(cyc)), 2'd0);
        checkOutput("collect_yumi",  32'(yumi_o),  32'(v));
        checkOutput("collect_done",  32'(done_o),  32'd0);
        checkOutput("collect_flush", 32'(flush_o), 32'd0);
        if (v) got++;
        cyc++;
      end

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF1111, 2'd0);
      checkOutput("done_flag", 32'(done_o), 32'd1);
      checkOutput("done_busy", 32'(busy_o), 32'd0);
      checkOutput("done_yumi", 32'(yumi_o), 32'd0);
      checkOutput("rd_data",   rd_data_o, res_exp[0]);
      for (int a = 1; a < 4; a++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'(a));
        checkOutput("rd_data", rd_data_o, res_exp[a]);
      end

      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
      checkOutput("done_hold", 32'(done_o), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
      checkOutput("rearm_done",     32'(done_o),     32'd0);
      checkOutput("rearm_ld_ready", 32'(ld_ready_o), 32'd1);
    end

    // Reset in the middle of result collection.
    for (int i = 0; i < 8; i++) begin
      ops_exp[i] = $urandom;
      applyStimulus(1'b1, 1'b0, 1'b1, ops_exp[i], 1'b1, 1'b0, 32'h0, 2'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
      checkOutput("mr_send_data", data_o, ops_exp[i]);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
    checkOutput("mr_flush", 32'(flush_o), 32'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, $urandom, 2'd0);
      checkOutput("mr_yumi", 32'(yumi_o), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5555, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6666, 2'd0);
    checkOutput("mr_busy",     32'(busy_o),     32'd0);
    checkOutput("mr_done",     32'(done_o),     32'd0);
    checkOutput("mr_yumi_off", 32'(yumi_o),     32'd0);
    checkOutput("mr_ld_ready", 32'(ld_ready_o), 32'd1);
    checkOutput("mr_valid",    32'(valid_o),    32'd0);
    checkOutput("mr_flush_off", 32'(flush_o),   32'd0);

    // The load count was cleared by reset, so an immediate start is refused.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0);
    checkOutput("post_rst_start_valid", 32'(valid_o), 32'd0);
    checkOutput("post_rst_start_busy",  32'(busy_o),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
